// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply front end and its benches.
package systolic_pkg;

    typedef enum logic [2:0] {
        LOAD,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

    // Number of cycles the skewed operand wavefront occupies for an N x N array.
    function automatic int stream_len(input int n);
        return 2 * n - 1;
    endfunction

    // Width of the beat and stream counters: wide enough for 0..2N-1.
    function automatic int cnt_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/systolic_skew_feeder.sv
// Buffers operand A (row per beat) and B (column per beat), then plays them
// into the systolic array as diagonally skewed, zero-padded lanes, clears the
// array's accumulators beforehand and flags when the array result is final.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE   = 16,
    parameter int MATRIX_SIZE = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  load_valid,
    output logic                                  load_ready,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] load_a_row,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] load_b_col,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_a,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_b,
    output logic                                  array_clear,
    output logic                                  busy,
    output logic                                  done
);

    localparam int CW = cnt_w(MATRIX_SIZE);
    localparam logic [CW-1:0] LAST_BEAT  = CW'(MATRIX_SIZE - 1);
    localparam logic [CW-1:0] LAST_T     = CW'(stream_len(MATRIX_SIZE) - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(MATRIX_SIZE - 1);

    typedef logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] lane_vec_t;

    feeder_state_t state_q, state_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // a_buf_q[k] holds row k of A; b_buf_q[k] holds column k of B.
    lane_vec_t [MATRIX_SIZE-1:0] a_buf_q, a_buf_d;
    lane_vec_t [MATRIX_SIZE-1:0] b_buf_q, b_buf_d;

    logic accept;
    logic stream_en;

    // Lane l at stream step t carries element t-l of its stored vector, or zero
    // while the diagonal wavefront has not reached / has already left that lane.
    function automatic logic [DATA_SIZE-1:0] skew_pick(input lane_vec_t vec,
                                                       input logic [CW-1:0] t,
                                                       input int lane);
        skew_pick = '0;
        for (int k = 0; k < MATRIX_SIZE; k++) begin
            if (t == CW'(lane + k)) begin
                skew_pick = vec[k];
            end
        end
    endfunction

    assign accept = load_valid && load_ready;

    // Control registers: FSM state and the two counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand buffers hold data only, so they are left out of reset.
    always_ff @(posedge clk) begin
        a_buf_q <= a_buf_d;
        b_buf_q <= b_buf_d;
    end

    // Next-state logic: load N beats, clear, stream 2N-1 steps, drain N, done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (accept && (beat_q == LAST_BEAT)) state_d = CLEAR;
            CLEAR:   state_d = STREAM;
            STREAM:  if (cnt_q == LAST_T) state_d = DRAIN;
            DRAIN:   if (cnt_q == LAST_DRAIN) state_d = DONE;
            DONE:    state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Beat counter advances per accepted beat; step counter runs in STREAM and DRAIN.
    always_comb begin
        beat_d = beat_q;
        cnt_d  = '0;
        if (accept) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
        case (state_q)
            STREAM:  cnt_d = (cnt_q == LAST_T) ? '0 : cnt_q + 1'b1;
            DRAIN:   cnt_d = (cnt_q == LAST_DRAIN) ? '0 : cnt_q + 1'b1;
            default: cnt_d = '0;
        endcase
    end

    // Beat k lands in buffer slot k for both operands.
    always_comb begin
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        for (int k = 0; k < MATRIX_SIZE; k++) begin
            if (accept && (beat_q == CW'(k))) begin
                a_buf_d[k] = load_a_row;
                b_buf_d[k] = load_b_col;
            end
        end
    end

    // Output decode from the registered state only.
    always_comb begin
        load_ready  = 1'b0;
        array_clear = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        stream_en   = 1'b0;
        case (state_q)
            LOAD:    load_ready = 1'b1;
            CLEAR: begin
                array_clear = 1'b1;
                busy        = 1'b1;
            end
            STREAM: begin
                busy      = 1'b1;
                stream_en = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: load_ready = 1'b0;
        endcase
    end

    // Skew mux: row i of A feeds in_a[i], column j of B feeds in_b[j].
    for (genvar g = 0; g < MATRIX_SIZE; g++) begin : g_lane
        assign out_a[g] = stream_en ? skew_pick(a_buf_q[g], cnt_q, g) : '0;
        assign out_b[g] = stream_en ? skew_pick(b_buf_q[g], cnt_q, g) : '0;
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: N=3 instance against a cycle model plus a
// behavioural systolic array, and an N=2 instance against hand-worked values.
module tb_systolic_skew_feeder;

    localparam int N  = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                    load_valid = 1'b0;
    logic                    load_ready;
    logic [N-1:0][DW-1:0]    load_a_row = '0;
    logic [N-1:0][DW-1:0]    load_b_col = '0;
    logic [N-1:0][DW-1:0]    out_a, out_b;
    logic                    array_clear, busy, done;

    logic                    v2 = 1'b0;
    logic                    r2;
    logic [1:0][DW-1:0]      a2 = '0, b2 = '0;
    logic [1:0][DW-1:0]      oa2, ob2;
    logic                    clr2, busy2, done2;

    systolic_skew_feeder #(.DATA_SIZE(DW), .MATRIX_SIZE(N)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_a_row(load_a_row), .load_b_col(load_b_col), .out_a(out_a), .out_b(out_b),
        .array_clear(array_clear), .busy(busy), .done(done)
    );

    systolic_skew_feeder #(.DATA_SIZE(DW), .MATRIX_SIZE(2)) dut2 (
        .clk(clk), .reset(reset), .load_valid(v2), .load_ready(r2),
        .load_a_row(a2), .load_b_col(b2), .out_a(oa2), .out_b(ob2),
        .array_clear(clr2), .busy(busy2), .done(done2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] pack3(input int x0, input int x1, input int x2);
        return {DW'(x2), DW'(x1), DW'(x0)};
    endfunction

    // ---------------- model: phase counted from the last accepted beat ----------------
    int m_cyc = 0, m_beats = 0;
    int m_A[N][N];
    int m_B[N][N];

    always @(posedge clk) begin
        if (reset) begin
            m_cyc   <= 0;
            m_beats <= 0;
        end else if (m_cyc == 0) begin
            if (load_valid) begin
                for (int i = 0; i < N; i++) begin
                    m_A[m_beats][i] <= int'(load_a_row[i]);
                    m_B[i][m_beats] <= int'(load_b_col[i]);
                end
                if (m_beats == N - 1) begin
                    m_beats <= 0;
                    m_cyc   <= 1;
                end else begin
                    m_beats <= m_beats + 1;
                end
            end
        end else begin
            m_cyc <= (m_cyc == 3 * N + 1) ? 0 : m_cyc + 1;
        end
    end

    logic [3:0]          exp_ctrl;
    logic [N*DW-1:0]     exp_a, exp_b;
    int                  exp_c[N][N];

    always_comb begin
        int t;
        exp_ctrl = {m_cyc == 0, m_cyc == 1, (m_cyc >= 1) && (m_cyc <= 3 * N), m_cyc == 3 * N + 1};
        exp_a = '0;
        exp_b = '0;
        t = m_cyc - 2;
        if (m_cyc >= 2 && m_cyc <= 2 * N) begin
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) begin
                    exp_a[i*DW +: DW] = DW'(m_A[i][t-i]);
                    exp_b[i*DW +: DW] = DW'(m_B[t-i][i]);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                exp_c[i][j] = 0;
                for (int k = 0; k < N; k++) exp_c[i][j] = exp_c[i][j] + m_A[i][k] * m_B[k][j];
            end
        end
    end

    // ---------------- behavioural output-stationary systolic array ----------------
    int ar[N][N], br[N][N], acc[N][N], ain[N][N], bin[N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ain[i][0] = int'(out_a[i]);
            bin[0][i] = int'(out_b[i]);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) begin
                ain[i][j] = ar[i][j-1];
                bin[j][i] = br[j-1][i];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (array_clear) begin
                    acc[i][j] <= 0;
                    ar[i][j]  <= 0;
                    br[i][j]  <= 0;
                end else begin
                    acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
                    ar[i][j]  <= ain[i][j];
                    br[i][j]  <= bin[i][j];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("ctrl", {load_ready, array_clear, busy, done}, exp_ctrl);
            check("out_a", out_a, exp_a);
            check("out_b", out_b, exp_b);
            if (done) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        check("array_result", acc[i][j], exp_c[i][j]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int A_NOM[N][N] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    int B_NOM[N][N] = '{'{2, 1, 3}, '{4, 5, 7}, '{6, 9, 8}};
    int B_ID[N][N]  = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    int C_LIT[N][N] = '{'{28, 38, 41}, '{64, 83, 95}, '{100, 128, 149}};
    int LIT_A[5][N] = '{'{1, 0, 0}, '{2, 4, 0}, '{3, 5, 7}, '{0, 6, 8}, '{0, 0, 9}};
    int LIT_B[5][N] = '{'{2, 0, 0}, '{4, 1, 0}, '{6, 5, 3}, '{0, 9, 7}, '{0, 0, 8}};

    logic [N*DW-1:0] cap_a[16], cap_b[16];
    int clr_cnt, first_wait, lat;

    // Loads one operation and follows it to done; abort_t >= 0 resets mid-stream at that step.
    task automatic run_op(input int A[N][N], input int B[N][N], input bit gapped,
                          input bit hold_valid, input int abort_t);
        int g, n, pulses;
        for (int k = 0; k < N; k++) begin
            if (gapped && k > 0) begin
                load_valid = 1'b0;
                @(negedge clk);
            end
            for (int i = 0; i < N; i++) begin
                load_a_row[i] = DW'(A[k][i]);
                load_b_col[i] = DW'(B[i][k]);
            end
            load_valid = 1'b1;
            g = 0;
            while (!load_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (k == 0) first_wait = g;
            if (g >= 100) check("ready_timeout", 64'(g), 64'd0);
            @(negedge clk);
        end
        if (hold_valid) begin
            for (int i = 0; i < N; i++) begin
                load_a_row[i] = 16'hDEAD;
                load_b_col[i] = 16'hBEEF;
            end
        end else begin
            load_valid = 1'b0;
        end
        n = 1;
        clr_cnt = int'(array_clear);
        cap_a[1] = out_a;
        cap_b[1] = out_b;
        if (abort_t >= 0) begin
            while (n < abort_t + 2) begin
                @(negedge clk);
                n++;
            end
            load_valid = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            check("abort_ctrl", {load_ready, array_clear, busy, done}, 4'b1000);
            check("abort_data", {out_a, out_b}, 0);
            reset = 1'b0;
            pulses = 0;
            repeat (15) begin
                @(negedge clk);
                pulses += int'(done);
            end
            check("abort_no_done", 64'(pulses), 64'd0);
            return;
        end
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (n < 16) begin
                cap_a[n] = out_a;
                cap_b[n] = out_b;
            end
            clr_cnt += int'(array_clear);
        end
        lat = n;
        load_valid = 1'b0;
        check("latency", 64'(n), 64'(3 * N + 1));
        check("clear_pulses", 64'(clr_cnt), 64'd1);
    endtask

    task automatic check_nominal_stream();
        for (int t = 0; t < 5; t++) begin
            check("lit_out_a", cap_a[t+2], pack3(LIT_A[t][0], LIT_A[t][1], LIT_A[t][2]));
            check("lit_out_b", cap_b[t+2], pack3(LIT_B[t][0], LIT_B[t][1], LIT_B[t][2]));
        end
        check("lit_clear_zero", {cap_a[1], cap_b[1]}, 0);
        check("lit_drain_zero", {cap_a[7] | cap_a[8] | cap_a[9], cap_b[7] | cap_b[8] | cap_b[9]}, 0);
    endtask

    logic [31:0] c2a[16], c2b[16];

    initial begin
        int g, n, s;
        int A2[2][2] = '{'{1, 2}, '{3, 4}};
        int B2[2][2] = '{'{5, 6}, '{7, 8}};
        int C2[2][2] = '{'{19, 22}, '{43, 50}};

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_ctrl", {load_ready, array_clear, busy, done}, 4'b1000);
        check("reset_data", {out_a, out_b}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", load_ready, 1'b1);

        // Nominal, then back-to-back gapped run with the same data.
        run_op(A_NOM, B_NOM, 1'b0, 1'b0, -1);
        check_nominal_stream();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) check("lit_result", acc[i][j], C_LIT[i][j]);
        run_op(A_NOM, B_NOM, 1'b1, 1'b0, -1);
        check("back_to_back_wait", 64'(first_wait), 64'd1);
        check_nominal_stream();

        // load_valid held through busy with junk data, then identity B.
        run_op(A_NOM, B_NOM, 1'b0, 1'b1, -1);
        check_nominal_stream();
        run_op(A_NOM, B_ID, 1'b0, 1'b0, -1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) check("identity_result", acc[i][j], A_NOM[i][j]);

        // Reset mid-stream, then a fresh load.
        run_op(A_NOM, B_NOM, 1'b0, 1'b0, 2);
        run_op(A_NOM, B_NOM, 1'b0, 1'b0, -1);
        check_nominal_stream();

        // N = 2 instance.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                a2[i] = DW'(A2[k][i]);
                b2[i] = DW'(B2[i][k]);
            end
            v2 = 1'b1;
            g = 0;
            while (!r2 && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) check("n2_ready_timeout", 64'(g), 64'd0);
            @(negedge clk);
        end
        v2 = 1'b0;
        n = 1;
        c2a[1] = oa2;
        c2b[1] = ob2;
        s = int'(clr2);
        while (!done2 && n < 60) begin
            @(negedge clk);
            n++;
            if (n < 16) begin
                c2a[n] = oa2;
                c2b[n] = ob2;
            end
            s += int'(clr2);
        end
        check("n2_latency", 64'(n), 64'd7);
        check("n2_clear_pulses", 64'(s), 64'd1);
        check("n2_t0", {c2a[2], c2b[2]}, {32'h0000_0001, 32'h0000_0005});
        check("n2_t1", {c2a[3], c2b[3]}, {32'h0003_0002, 32'h0006_0007});
        check("n2_t2", {c2a[4], c2b[4]}, {32'h0004_0000, 32'h0008_0000});
        check("n2_drain", {c2a[5] | c2a[6], c2b[5] | c2b[6]}, 64'd0);
        check("n2_busy_at_done", {busy2, r2}, 2'b00);
        // PE(i,j) sees lane i of A delayed by j and lane j of B delayed by i.
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int c = 1; c <= 8; c++) begin
                    if (c - j >= 1 && c - i >= 1 && c - j <= 7 && c - i <= 7)
                        s += int'(c2a[c-j][i*DW +: DW]) * int'(c2b[c-i][j*DW +: DW]);
                end
                check("n2_result", 64'(s), 64'(C2[i][j]));
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the MATRIX_SIZE x MATRIX_SIZE systolic matrix_multiply array.
- Accepts operand A row-by-row and operand B column-by-column through a valid/ready load port and buffers both matrices.
- Emits the diagonally skewed, zero-padded in_a/in_b streams the array consumes, plus the array's accumulator clear.
- Signals done once the array's out_matrix is final.

Parameters:
- DATA_SIZE, 16, bit width of every operand element and output lane.
- MATRIX_SIZE, 3, N, the matrix dimension. Must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  a load beat is presented.
- load_ready  output  1  the feeder accepts a beat this cycle.
- load_a_row  input  [DATA_SIZE-1:0] x MATRIX_SIZE  row k of A; element [i] = A[k][i].
- load_b_col  input  [DATA_SIZE-1:0] x MATRIX_SIZE  column k of B; element [j] = B[j][k].
- out_a  output  [DATA_SIZE-1:0] x MATRIX_SIZE  drives the array's in_a.
- out_b  output  [DATA_SIZE-1:0] x MATRIX_SIZE  drives the array's in_b.
- array_clear  output  1  drives the array's reset input.
- busy  output  1  high in CLEAR, STREAM and DRAIN.
- done  output  1  one-cycle pulse; the array's out_matrix is final.

Behaviour:
- Reset (synchronous, active-high):
  - state = LOAD, beat counter = 0, stream counter = 0.
  - out_a/out_b = 0, array_clear = 0, busy = 0, done = 0.
  - load_ready = 1 in the first cycle after reset deasserts.
  - Reset in any state, including mid-STREAM, abandons the buffered matrices. The buffer contents need not be cleared; the beat count restarts at 0.
- Outputs are driven only from registered state and the buffer; there is no combinational path from inputs to outputs.
- LOAD:
  - load_ready = 1.
  - A beat transfers when load_valid && load_ready. Beat k writes A row k and B column k, with k = 0..N-1 in arrival order.
  - Gaps in load_valid are allowed.
  - On the transfer of beat N-1, the next state is CLEAR.
- CLEAR (1 cycle): array_clear = 1, out_a/out_b = 0, load_ready = 0. Next state is STREAM with t = 0.
- STREAM (2N-1 cycles, t = 0..2N-2):
  - out_a[i] = A[i][t-i] when 0 <= t-i < N, else 0.
  - out_b[j] = B[t-j][j] when 0 <= t-j < N, else 0.
  - After t = 2N-2, the next state is DRAIN.
- DRAIN (N cycles): out_a/out_b = 0. Gives the last operands time to reach PE(N-1,N-1). Next state is DONE.
- DONE (1 cycle): done = 1, busy = 0, load_ready = 0. Next state is LOAD.
- Timing:
  - From the accepting edge of the last beat to done is 1 + (2N-1) + N + 1 = 3N+1 cycles (10 for N = 3).
  - Back-to-back operation: the first beat of the next operation is accepted the cycle after DONE.
- Boundary behaviour:
  - load_valid high while load_ready is low: ignored, no buffer write.
  - array_clear is never asserted outside CLEAR.
  - Widths: counters are $clog2(2N) bits. No arithmetic is done on data; elements pass through unmodified.

Decomposition:
- Shared package systolic_pkg holds:
  - typedef enum feeder_state_t {LOAD, CLEAR, STREAM, DRAIN, DONE};
  - the function stream_len(N) = 2N-1;
  - the constant-width helper for counters.
- The same package is reused by matrix_multiply benches.
- No sub-module. The skew mux is a generate loop inside the block.

Test Plan:
- Nominal skew: load A = [1 2 3; 4 5 6; 7 8 9] and B = [2 1 3; 4 5 7; 6 9 8]. Required (out_a; out_b) for t = 0..4:
  - t=0: (1,0,0; 2,0,0)
  - t=1: (2,4,0; 4,1,0)
  - t=2: (3,5,7; 6,5,3)
  - t=3: (0,6,8; 0,9,7)
  - t=4: (0,0,9; 0,0,8)
  - Then zeros for 3 DRAIN cycles, then done.
- End-to-end: feeder wired to matrix_multiply (DATA_SIZE 16) with the same data. At the done cycle, out_matrix = 28 38 41 64 83 95 100 128 149.
- Gapped/illegal load: load_valid toggling 1,0,1,0,1 still yields exactly 3 beats and the same stream as above. load_valid held high through busy causes no buffer corruption; a second run with identity B gives out_matrix = A.
- Reset mid-STREAM at t = 2: the next cycle shows all outputs 0, load_ready = 1, done never pulses. A fresh load then produces a correct stream.
- Back-to-back: a second load starts the cycle after done. array_clear pulses exactly once per operation. Check the 3N+1 = 10 cycle latency from the last beat to done for each operation.
- N = 2 parameter sweep: A = [1 2; 3 4], B = [5 6; 7 8]. Stream length is 3 and DRAIN is 2. End-to-end result = 19 22 43 50.
